mem_arbiter: RTL and testbench

Two-requester arbiter that shares one data-memory bus between requester 0 (hart/data side) and requester 1 (instruction-fetch or second hart). It sits between the memory-stage/fetch logic and the single external memory port. It serialises accesses with one outstanding transaction, round-robin fairness and a lock for atomic read-modify-write sequences. Request fields are captured into registers, so the memory side sees registered outputs.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StLocked
  } arb_state_e;

  localparam int unsigned NUM_REQ = 2;
  localparam logic        REQ0    = 1'b0;
  localparam logic        REQ1    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: a lone requester wins, a tie goes to the
// requester that did not own the bus last.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_owner,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    winner = '0;
    unique case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = (last_owner == REQ0) ? 2'b10 : 2'b01;
      default: winner = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between two requesters: one outstanding access,
// round-robin on ties, and a lock that keeps ownership across an RMW pair.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_we,
  input  logic [NUM_REQ-1:0] i_lock,
  input  logic [2:0]         i_f3_0,
  input  logic [2:0]         i_f3_1,
  input  logic [ADDR_W-1:0]  i_addr_0,
  input  logic [ADDR_W-1:0]  i_addr_1,
  input  logic [DATA_W-1:0]  i_wdata_0,
  input  logic [DATA_W-1:0]  i_wdata_1,
  output logic [NUM_REQ-1:0] o_ack,
  output logic [DATA_W-1:0]  o_rdata,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [2:0]         o_mem_f3,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  input  logic               i_mem_ack,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  output logic               o_stray_ack
);

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [2:0]           f3_q, f3_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 stray_q;

  logic [NUM_REQ-1:0]   winner;
  logic                 capture;
  logic                 cap_idx;
  logic                 mem_done;

  rr_pick u_rr_pick (
    .req        (i_req),
    .last_owner (last_owner_q),
    .winner     (winner)
  );

  assign mem_done = (state_q == StBusy) && i_mem_ack;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    capture      = 1'b0;
    cap_idx      = owner_q;

    unique case (state_q)
      StIdle: begin
        if (winner[REQ0]) begin
          capture = 1'b1;
          cap_idx = REQ0;
        end else if (winner[REQ1]) begin
          capture = 1'b1;
          cap_idx = REQ1;
        end
      end
      StBusy: begin
        if (i_mem_ack) begin
          if (i_lock[owner_q]) begin
            state_d = StLocked;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end
      end
      StLocked: begin
        // Only the lock holder is considered; the other requester waits.
        if (i_req[owner_q]) begin
          capture = 1'b1;
          cap_idx = owner_q;
        end else if (!i_lock[owner_q]) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase

    if (capture) begin
      state_d      = StBusy;
      owner_d      = cap_idx;
      last_owner_d = cap_idx;
      gnt_d        = (cap_idx == REQ1) ? 2'b10 : 2'b01;
      we_d         = i_we[cap_idx];
      f3_d         = (cap_idx == REQ1) ? i_f3_1 : i_f3_0;
      addr_d       = (cap_idx == REQ1) ? i_addr_1 : i_addr_0;
      wdata_d      = (cap_idx == REQ1) ? i_wdata_1 : i_wdata_0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      owner_q      <= REQ0;
      last_owner_q <= REQ1;
      gnt_q        <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if (i_mem_ack && (state_q != StBusy)) begin
        stray_q <= 1'b1;
      end
    end
  end

  always_comb begin
    o_ack = '0;
    if (mem_done) begin
      o_ack = (owner_q == REQ1) ? 2'b10 : 2'b01;
    end
  end

  assign o_rdata     = mem_done ? i_mem_rdata : '0;
  assign o_gnt       = gnt_q;
  assign o_mem_req   = (state_q == StBusy);
  assign o_mem_we    = we_q;
  assign o_mem_f3    = f3_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_stray_ack = stray_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req, i_we, i_lock;
  logic [2:0]  i_f3_0, i_f3_1;
  logic [31:0] i_addr_0, i_addr_1, i_wdata_0, i_wdata_1;
  logic [1:0]  o_ack, o_gnt;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic        o_mem_req, o_mem_we, i_mem_ack, o_stray_ack;
  logic [2:0]  o_mem_f3;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_lock      (i_lock),
    .i_f3_0      (i_f3_0),
    .i_f3_1      (i_f3_1),
    .i_addr_0    (i_addr_0),
    .i_addr_1    (i_addr_1),
    .i_wdata_0   (i_wdata_0),
    .i_wdata_1   (i_wdata_1),
    .o_ack       (o_ack),
    .o_rdata     (o_rdata),
    .o_gnt       (o_gnt),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_f3    (o_mem_f3),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_stray_ack (o_stray_ack)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_req = '0; i_we = '0; i_lock = '0;
    i_f3_0 = '0; i_f3_1 = '0;
    i_addr_0 = '0; i_addr_1 = '0; i_wdata_0 = '0; i_wdata_1 = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    do_reset();
    i_rst = 1'b1;
    #1;
    check("rst_gnt", o_gnt, 0);
    check("rst_mem_req", o_mem_req, 0);
    check("rst_ack", o_ack, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_stray", o_stray_ack, 0);
    do_reset();

    // Single read from requester 0.
    tick(); i_req = 2'b01; i_addr_0 = 32'h100; i_f3_0 = 3'd2; #1;
    check("s1_idle_req", o_mem_req, 0);
    tick(); #1;
    check("s1_mem_req", o_mem_req, 1);
    check("s1_addr", o_mem_addr, 32'h100);
    check("s1_f3", o_mem_f3, 2);
    check("s1_gnt", o_gnt, 2'b01);
    check("s1_no_ack", o_ack, 0);
    tick(); i_mem_ack = 1'b1; i_mem_rdata = 32'hDEADBEEF; #1;
    check("s1_req_in_ack", o_mem_req, 1);
    check("s1_ack", o_ack, 2'b01);
    check("s1_rdata", o_rdata, 32'hDEADBEEF);
    tick(); i_mem_ack = 1'b0; i_req = 2'b00; #1;
    check("s1_req_drop", o_mem_req, 0);
    check("s1_gnt_clr", o_gnt, 0);
    check("s1_stray", o_stray_ack, 0);

    // Ties: after reset requester 0 wins, then round-robin alternates.
    do_reset();
    tick(); i_req = 2'b11; i_addr_0 = 32'h200; i_addr_1 = 32'h300; #1;
    tick(); #1;
    check("t1_gnt0", o_gnt, 2'b01);
    check("t1_addr0", o_mem_addr, 32'h200);
    tick(); i_mem_ack = 1'b1; #1;
    check("t1_ack0", o_ack, 2'b01);
    tick(); i_mem_ack = 1'b0; i_req = 2'b10; #1;
    check("t1_idle_gap", o_gnt, 0);
    check("t1_idle_req", o_mem_req, 0);
    tick(); i_mem_ack = 1'b1; #1;
    check("t1_gnt1", o_gnt, 2'b10);
    check("t1_addr1", o_mem_addr, 32'h300);
    check("t1_ack1_zw", o_ack, 2'b10);
    tick(); i_mem_ack = 1'b0; i_req = 2'b01; #1;
    tick(); i_mem_ack = 1'b1; #1;
    check("t2_solo0_ack", o_ack, 2'b01);
    tick(); i_mem_ack = 1'b0; i_req = 2'b11; #1;
    tick(); i_mem_ack = 1'b1; #1;
    check("t2_tie_gnt1", o_gnt, 2'b10);
    check("t2_tie_ack1", o_ack, 2'b10);
    tick(); i_mem_ack = 1'b0; i_req = 2'b01; #1;
    tick(); i_mem_ack = 1'b1; #1;
    check("t2_then_gnt0", o_gnt, 2'b01);
    check("t2_then_ack0", o_ack, 2'b01);
    tick(); i_mem_ack = 1'b0; i_req = 2'b00; #1;

    // Locked read-modify-write by requester 0 with requester 1 pending.
    do_reset();
    tick(); i_req = 2'b11; i_lock = 2'b01; i_addr_0 = 32'h200; i_addr_1 = 32'h300; #1;
    tick(); i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0005; #1;
    check("l_rd_ack", o_ack, 2'b01);
    check("l_rd_data", o_rdata, 32'h5);
    tick(); i_mem_ack = 1'b0; i_req = 2'b10; #1;
    check("l_locked_req", o_mem_req, 0);
    check("l_locked_gnt", o_gnt, 2'b01);
    tick(); i_req = 2'b11; i_we = 2'b01; i_wdata_0 = 32'hCAFEF00D; #1;
    check("l_hold_gnt", o_gnt, 2'b01);
    check("l_hold_req", o_mem_req, 0);
    tick(); i_mem_ack = 1'b1; i_lock = 2'b00; #1;
    check("l_wr_req", o_mem_req, 1);
    check("l_wr_we", o_mem_we, 1);
    check("l_wr_addr", o_mem_addr, 32'h200);
    check("l_wr_data", o_mem_wdata, 32'hCAFEF00D);
    check("l_wr_ack", o_ack, 2'b01);
    tick(); i_mem_ack = 1'b0; i_req = 2'b10; i_we = 2'b00; #1;
    check("l_unlock_gnt", o_gnt, 0);
    tick(); i_mem_ack = 1'b1; #1;
    check("l_req1_gnt", o_gnt, 2'b10);
    check("l_req1_addr", o_mem_addr, 32'h300);
    check("l_req1_ack", o_ack, 2'b10);

    // Zero-wait back-to-back writes from requester 1.
    tick(); i_mem_ack = 1'b0; i_req = 2'b10; i_we = 2'b10; i_addr_1 = 32'h10;
    i_wdata_1 = 32'h1111_1111; i_f3_1 = 3'd1; #1;
    check("z_gap0", o_mem_req, 0);
    tick(); i_mem_ack = 1'b1; #1;
    check("z_req1", o_mem_req, 1);
    check("z_addr1", o_mem_addr, 32'h10);
    check("z_data1", o_mem_wdata, 32'h1111_1111);
    check("z_f3_1", o_mem_f3, 1);
    check("z_we1", o_mem_we, 1);
    tick(); i_mem_ack = 1'b0; i_addr_1 = 32'h14; i_wdata_1 = 32'h2222_2222; i_f3_1 = 3'd2; #1;
    check("z_gap1", o_mem_req, 0);
    tick(); i_mem_ack = 1'b1; #1;
    check("z_req2", o_mem_req, 1);
    check("z_addr2", o_mem_addr, 32'h14);
    check("z_data2", o_mem_wdata, 32'h2222_2222);
    check("z_f3_2", o_mem_f3, 2);
    check("z_ack2", o_ack, 2'b10);
    tick(); i_mem_ack = 1'b0; i_req = 2'b00; i_we = 2'b00; #1;
    check("z_drop", o_mem_req, 0);

    // Reset while busy, then a stray memory ack.
    tick(); i_req = 2'b01; i_addr_0 = 32'h40; #1;
    tick(); #1;
    check("r_busy", o_mem_req, 1);
    i_rst = 1'b1; #1;
    check("r_async_req", o_mem_req, 0);
    check("r_async_gnt", o_gnt, 0);
    check("r_async_addr", o_mem_addr, 0);
    tick(); i_rst = 1'b0; i_req = 2'b00; i_mem_ack = 1'b1; #1;
    check("r_stray_noack", o_ack, 0);
    check("r_stray_pre", o_stray_ack, 0);
    tick(); i_mem_ack = 1'b0; #1;
    check("r_stray_set", o_stray_ack, 1);
    tick(); tick(); #1;
    check("r_stray_sticky", o_stray_ack, 1);
    i_rst = 1'b1; #1;
    check("r_stray_clr", o_stray_ack, 0);
    i_rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
